// File: rtl/inport_fifo_if.sv
// Handshake and status bundle between a link-side producer and one inport_fifo instance.
// The slave modport is the FIFO side; the master modport is the upstream/arbiter side.
interface inport_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  full;
  logic                  grant;
  logic [DATA_WIDTH-1:0] data_out;
  logic [2:0]            flit_id;
  logic [11:0]           length;
  logic                  req;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  proto_err;

  modport master (
    output data_in, wr_en, grant,
    input  full, data_out, flit_id, length, req, empty, count, proto_err
  );

  modport slave (
    input  data_in, wr_en, grant,
    output full, data_out, flit_id, length, req, empty, count, proto_err
  );
endinterface

// File: rtl/inport_fifo.sv
// Router input-port buffer: framing check on write, show-ahead FIFO, request to the arbiter.
// Optional INPORT_PKT_HOLD_EN keeps req asserted across mid-packet underrun.
module inport_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input logic        clk,
  input logic        rst,
  inport_fifo_if.slave bus
);

  localparam logic [2:0] IdHead = 3'b001;
  localparam logic [2:0] IdBody = 3'b010;
  localparam logic [2:0] IdTail = 3'b100;
  localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {WIdle, WPkt} wstate_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  wstate_e               wstate_q, wstate_d;
  logic                  proto_err_q, proto_err_d;
  logic                  full, empty, accept, push, pop;
  logic [2:0]            in_id;
  logic [DATA_WIDTH-1:0] head;

  assign full   = (count_q == CountFull);
  assign empty  = (count_q == '0);
  assign accept = bus.wr_en && !full;
  assign pop    = bus.grant && !empty;
  assign in_id  = bus.data_in[2:0];
  assign head   = empty ? '0 : mem_q[rd_ptr_q];

  // Framing FSM: only legally sequenced flits are stored, the rest are dropped with a pulse.
  always_comb begin
    wstate_d    = wstate_q;
    push        = 1'b0;
    proto_err_d = 1'b0;
    if (accept) begin
      case (wstate_q)
        WIdle: begin
          if (in_id == IdHead) begin
            push     = 1'b1;
            wstate_d = WPkt;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        WPkt: begin
          if (in_id == IdBody) begin
            push = 1'b1;
          end else if (in_id == IdTail) begin
            push     = 1'b1;
            wstate_d = WIdle;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        default: wstate_d = WIdle;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wstate_q    <= WIdle;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      wstate_q    <= wstate_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef INPORT_PKT_HOLD_EN
  typedef enum logic {RIdle, RPkt} rstate_e;

  rstate_e rstate_q, rstate_d;

  always_comb begin
    rstate_d = rstate_q;
    if (pop) begin
      case (rstate_q)
        RIdle:   if (head[2:0] == IdHead) rstate_d = RPkt;
        RPkt:    if (head[2:0] == IdTail) rstate_d = RIdle;
        default: rstate_d = RIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rstate_q <= RIdle;
    else     rstate_q <= rstate_d;
  end

  // Hold the request through an underrun so the arbiter stays on this packet.
  assign bus.req = !empty || (rstate_q == RPkt);
`else
  assign bus.req = !empty;
`endif

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.count     = count_q;
  assign bus.data_out  = head;
  assign bus.flit_id   = head[2:0];
  assign bus.length    = head[14:3];
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_inport_fifo.sv
// Scoreboard bench for inport_fifo: stimulus pushes expected flits, a monitor checks every pop.
module tb_inport_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inport_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  inport_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];
  int m_cnt;
  bit m_wpkt;
  bit m_rpkt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [11:0] len,
                                       input logic [16:0] tag);
    return {tag, len, id};
  endfunction

  // Monitor: every DUT pop must match the oldest expected flit.
  always @(posedge clk) begin
    if (!rst && bus.grant && !bus.empty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no pop", bus.data_out);
      end else begin
        chk("pop_data", bus.data_out, sb.pop_front());
      end
    end
  end

  task automatic check_state(input bit exp_err);
    logic [DW-1:0] exp_head;
    bit exp_req;
    exp_head = (sb.size() > 0) ? sb[0] : '0;
`ifdef INPORT_PKT_HOLD_EN
    exp_req = (m_cnt > 0) || m_rpkt;
`else
    exp_req = (m_cnt > 0);
`endif
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("empty", 32'(bus.empty), 32'(m_cnt == 0));
    chk("full", 32'(bus.full), 32'(m_cnt == DEPTH));
    chk("req", 32'(bus.req), 32'(exp_req));
    chk("proto_err", 32'(bus.proto_err), 32'(exp_err));
    chk("data_out", bus.data_out, exp_head);
    chk("flit_id", 32'(bus.flit_id), 32'(exp_head[2:0]));
    chk("length", 32'(bus.length), 32'(exp_head[14:3]));
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d, input bit g);
    bit push, pop, err;
    logic [2:0] id;
    @(negedge clk);
    bus.wr_en   = wr;
    bus.data_in = d;
    bus.grant   = g;
    push = 1'b0;
    err  = 1'b0;
    id   = d[2:0];
    if (wr && m_cnt < DEPTH) begin
      if (!m_wpkt) begin
        if (id == 3'b001) begin push = 1'b1; m_wpkt = 1'b1; end
        else err = 1'b1;
      end else begin
        if (id == 3'b010) push = 1'b1;
        else if (id == 3'b100) begin push = 1'b1; m_wpkt = 1'b0; end
        else err = 1'b1;
      end
    end
    pop = g && (m_cnt > 0);
    if (pop) begin
      id = sb[0][2:0];
      if (!m_rpkt && id == 3'b001) m_rpkt = 1'b1;
      else if (m_rpkt && id == 3'b100) m_rpkt = 1'b0;
    end
    if (push) sb.push_back(d);
    m_cnt = m_cnt + int'(push) - int'(pop);
    @(posedge clk);
    #1;
    check_state(err);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.grant   = 1'b0;
    bus.data_in = '0;
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    m_cnt  = 0;
    m_wpkt = 1'b0;
    m_rpkt = 1'b0;
    check_state(1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.grant   = 1'b0;
    bus.data_in = '0;

    // Reset, then one packet buffered and drained in order
    do_reset(2);
    step(1'b1, mk(3'b001, 12'h005, 17'h00a1), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h00a2), 1'b0);
    step(1'b1, mk(3'b100, 12'h000, 17'h00a3), 1'b0);
    drain(3);
    step(1'b0, '0, 1'b1);  // grant while empty is ignored

    // Full boundary: refused write, write with pop still refused, retry accepted
    step(1'b1, mk(3'b001, 12'h0ab, 17'h0b01), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0b02), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0b03), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0b04), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0b05), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0b05), 1'b1);
    step(1'b1, mk(3'b010, 12'h000, 17'h0b05), 1'b0);
    drain(2);
    step(1'b1, mk(3'b100, 12'h000, 17'h0b06), 1'b0);
    drain(3);

    // Framing errors
    do_reset(1);
    step(1'b1, mk(3'b010, 12'h000, 17'h0c01), 1'b0);
    step(1'b1, mk(3'b001, 12'h123, 17'h0c02), 1'b0);
    step(1'b1, mk(3'b001, 12'h456, 17'h0c03), 1'b0);
    step(1'b1, mk(3'b111, 12'h000, 17'h0c04), 1'b0);
    step(1'b1, mk(3'b100, 12'h000, 17'h0c05), 1'b0);
    drain(2);

    // Simultaneous write and pop at count 2
    step(1'b1, mk(3'b001, 12'hfff, 17'h0d01), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0d02), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0d03), 1'b1);
    step(1'b1, mk(3'b100, 12'h000, 17'h0d04), 1'b0);
    drain(3);

    // Reset mid-packet returns the framing FSM to idle
    step(1'b1, mk(3'b001, 12'h007, 17'h0e01), 1'b0);
    step(1'b1, mk(3'b010, 12'h000, 17'h0e02), 1'b0);
    do_reset(1);
    step(1'b1, mk(3'b010, 12'h000, 17'h0e03), 1'b0);

    // Underrun inside a packet
    step(1'b1, mk(3'b001, 12'h002, 17'h0f01), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, mk(3'b100, 12'h000, 17'h0f02), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inport_fifo.md
# inport_fifo

Per-port input buffer feeding the router's five-port round-robin arbiter. It accepts flits from the link, checks the header/body/tail packet framing, and stores legal flits in a show-ahead FIFO. It presents the head flit's `flit_id` and `length` to the arbiter and raises `req` toward it. Flits are popped when the arbiter's one-hot grant bit for this port is high. Five instances (L, N, E, W, S) sit directly upstream of the arbiter.

## Interface
- `DATA_WIDTH`, 32, flit width; must be ≥ 15.
- `DEPTH`, 4, FIFO entries; must be a power of two, ≥ 2.
- `ADDR_WIDTH`, 2, log2(`DEPTH`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input `DATA_WIDTH`: incoming flit. `[2:0]` is the flit id; `[14:3]` is the packet length (header flit only).
- `wr_en` input 1: `data_in` is valid this cycle.
- `full` output 1: FIFO holds `DEPTH` entries.
- `grant` input 1: arbiter grant bit for this port; pops the head flit.
- `data_out` output `DATA_WIDTH`: head flit; 0 when empty.
- `flit_id` output 3: `data_out[2:0]`.
- `length` output 12: `data_out[14:3]`.
- `req` output 1: request to arbiter.
- `empty` output 1: FIFO holds 0 entries.
- `count` output `ADDR_WIDTH+1`: occupancy, 0..`DEPTH`.
- `proto_err` output 1: one-cycle pulse; a framing-illegal flit was dropped.

## Operation
- Flit id codes: 3'b001 header, 3'b010 body, 3'b100 tail. Any other code is illegal.
- Storage: `DEPTH`-entry register array with write pointer, read pointer and occupancy counter. Pointers wrap modulo `DEPTH`.
- **Accept rule:** a flit is accepted when `wr_en && !full`. When `full`, `wr_en` is ignored: no write, no state change, no error; upstream holds the flit.
- **Write-side framing FSM**, states W_IDLE and W_PKT; reset state W_IDLE.
  - W_IDLE, header accepted → written, go to W_PKT.
  - W_IDLE, body/tail/illegal accepted → dropped, `proto_err` pulses.
  - W_PKT, body accepted → written, stay in W_PKT.
  - W_PKT, tail accepted → written, go to W_IDLE.
  - W_PKT, header/illegal accepted → dropped, `proto_err` pulses, stay in W_PKT.
  - Dropped flits do not change the pointers or `count`.
- **Pop:** `grant && !empty` pops the head flit. `grant` while empty is ignored.
- **Simultaneous write and pop:** a write and a pop in the same cycle leave `count` unchanged. When full, the write is still refused, even if a pop occurs that cycle.
- **req:** `req = !empty` (see Configuration for the alternative).

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `req`=0, `proto_err`=0. `data_out`, `flit_id` and `length` are all 0. Both FSMs start in their IDLE state and the pointers are 0.
- Reset mid-packet discards all contents and FSM state on the next edge.
- Write-to-visibility latency: a flit accepted at edge k appears on `data_out` after edge k when the FIFO was empty. `empty` falls and `req` rises after the same edge.
- `data_out`, `flit_id`, `length`, `empty`, `full` and `req` are combinational from registered state only; there is no combinational path from `data_in` or `grant`.
- `proto_err` is registered: it is high for exactly the one cycle after the offending accepting edge.
- The pop takes effect at the edge where `grant` is sampled high, and the next entry is visible after that edge.
- The arbiter's timer samples `length` while `flit_id`==3'b001. The header therefore stays at the head until granted, so `length` is valid for that whole interval.

## Configuration
- Macro: `INPORT_PKT_HOLD_EN`.
- **Defined:** adds a read-side FSM with states R_IDLE and R_PKT.
  - Popping a header moves R_IDLE → R_PKT.
  - Popping a tail moves R_PKT → R_IDLE.
  - `req = !empty || (state == R_PKT)`, so the request stays high across mid-packet FIFO underrun and the arbiter does not re-arbitrate inside a packet.
  - `grant` with empty still does not pop.
  - Reset state is R_IDLE.
- **Undefined:** no read-side FSM, and `req = !empty`.

## Test plan
- **Reset then single packet:** assert `rst` for 2 cycles. Write header (length 12'h005), body, tail on consecutive cycles with `grant`=0 → `count` reaches 3, `flit_id`=3'b001, `length`=12'h005, `req`=1. Then hold `grant`=1 for 3 cycles → the three flits pop in order, then `empty`=1 and `req`=0.
- **Full boundary:** `DEPTH`=4, write header + 3 bodies → `full`=1. A 5th write is refused and `count` stays 4. Next cycle, write together with `grant` → `count` goes 4→3 and the written flit is lost; upstream retries, and the retried flit is accepted.
- **Framing errors:** from reset, write a body → dropped, `proto_err` high one cycle, `count`=0. Then write header, header → second header dropped, `proto_err` pulses, `count`=1. Write id 3'b111 → dropped with a pulse.
- **Simultaneous read/write at count 2:** write plus `grant` in the same cycle → `count` stays 2 and the head advances by one.
- **Reset mid-packet:** header and body stored; pulse `rst` → `count`=0, `empty`=1. A following body write raises `proto_err`, which confirms the write FSM returned to W_IDLE.
- **`INPORT_PKT_HOLD_EN` underrun:** write header, grant it, FIFO goes empty → `req` stays 1. Write the tail → it pops on grant and `req` falls to 0. With the macro undefined, `req` drops to 0 as soon as the FIFO is empty.
